// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU opcodes, stall FSM states and control struct for the 19-bit CPU
package cpu_pkg;
  localparam int DATA_W  = 19;
  localparam int REG_W   = 3;
  localparam int ALUOP_W = 4;
  localparam logic [ALUOP_W-1:0] ALU_NOP = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd5;
  typedef enum logic {RUN, STALL} stall_state_t;
  typedef struct packed {
    logic memread;
    logic memwrite;
    logic regwrite;
    logic alusrc;
  } id_ex_ctrl_t;
endpackage

// File: rtl/stall_watchdog.sv
// stall_watchdog: RUN/STALL tracker with saturating consecutive-stall counter and sticky error
module stall_watchdog
  import cpu_pkg::*;
#(
  parameter int MAX_STALL = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic hazard,
  input  logic flush,
  output logic stall_err
);
  localparam int CW = $clog2(MAX_STALL + 1);
  stall_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic          w_at_max;
  assign w_at_max = r_cnt == CW'(MAX_STALL);
  // flush resets tracking; each hazard bubble counts, and a hazard arriving at the limit latches the error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      stall_err <= 1'b0;
    end else if (flush) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else if (hazard) begin
      r_state <= STALL;
      r_cnt   <= w_at_max ? r_cnt : r_cnt + CW'(1);
      if (r_state == STALL && w_at_max) stall_err <= 1'b1;
    end else begin
      r_state <= RUN;
      r_cnt   <= '0;
    end
endmodule

// File: rtl/id_ex_bubble_reg.sv
// id_ex_bubble_reg: ID/EX pipeline register inserting NOP bubbles on hazard/flush; ID_EX_STALL_COUNT_EN adds stall_cycles
module id_ex_bubble_reg #(
  parameter int DATA_W    = cpu_pkg::DATA_W,
  parameter int REG_W     = cpu_pkg::REG_W,
  parameter int ALUOP_W   = cpu_pkg::ALUOP_W,
  parameter int MAX_STALL = 4
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard,
  input  logic               flush,
  input  logic               ID_valid,
  input  logic [REG_W-1:0]   ID_rs,
  input  logic [REG_W-1:0]   ID_rt,
  input  logic [REG_W-1:0]   ID_rd,
  input  logic [DATA_W-1:0]  ID_rs_data,
  input  logic [DATA_W-1:0]  ID_rt_data,
  input  logic [DATA_W-1:0]  ID_imm,
  input  logic [ALUOP_W-1:0] ID_aluop,
  input  logic               ID_memread,
  input  logic               ID_memwrite,
  input  logic               ID_regwrite,
  input  logic               ID_alusrc,
  output logic               EX_valid,
  output logic [REG_W-1:0]   EX_rs,
  output logic [REG_W-1:0]   EX_rt,
  output logic [REG_W-1:0]   EX_rd,
  output logic [DATA_W-1:0]  EX_rs_data,
  output logic [DATA_W-1:0]  EX_rt_data,
  output logic [DATA_W-1:0]  EX_imm,
  output logic [ALUOP_W-1:0] EX_aluop,
  output logic               EX_memread,
  output logic               EX_memwrite,
  output logic               EX_regwrite,
  output logic               EX_alusrc,
  output logic               bubble,
  output logic               stall_err
`ifdef ID_EX_STALL_COUNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);
  cpu_pkg::id_ex_ctrl_t r_ctrl;
  cpu_pkg::id_ex_ctrl_t w_ctrl;
  logic                 w_load;
  logic                 w_hz_bubble;
  assign w_load      = ID_valid && !flush && !hazard;
  assign w_hz_bubble = hazard && !flush;
  assign w_ctrl      = '{memread: ID_memread, memwrite: ID_memwrite, regwrite: ID_regwrite, alusrc: ID_alusrc};
  assign EX_memread  = r_ctrl.memread;
  assign EX_memwrite = r_ctrl.memwrite;
  assign EX_regwrite = r_ctrl.regwrite;
  assign EX_alusrc   = r_ctrl.alusrc;
  // capture ID fields, or an all-zero NOP so a bubble never matches register 0 in hazard/forwarding
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      EX_valid   <= 1'b0;
      EX_rs      <= '0;
      EX_rt      <= '0;
      EX_rd      <= '0;
      EX_rs_data <= '0;
      EX_rt_data <= '0;
      EX_imm     <= '0;
      EX_aluop   <= '0;
      r_ctrl     <= '0;
      bubble     <= 1'b0;
    end else begin
      EX_valid   <= w_load;
      EX_rs      <= w_load ? ID_rs : '0;
      EX_rt      <= w_load ? ID_rt : '0;
      EX_rd      <= w_load ? ID_rd : '0;
      EX_rs_data <= w_load ? ID_rs_data : '0;
      EX_rt_data <= w_load ? ID_rt_data : '0;
      EX_imm     <= w_load ? ID_imm : '0;
      EX_aluop   <= w_load ? ID_aluop : ALUOP_W'(cpu_pkg::ALU_NOP);
      r_ctrl     <= w_load ? w_ctrl : '0;
      bubble     <= flush || hazard;
    end
  stall_watchdog #(.MAX_STALL(MAX_STALL)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .hazard    (hazard),
    .flush     (flush),
    .stall_err (stall_err)
  );
`ifdef ID_EX_STALL_COUNT_EN
  // saturating tally of hazard bubbles; flush bubbles are excluded
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cycles <= '0;
    else if (w_hz_bubble && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
`endif
endmodule

// File: doc/id_ex_bubble_reg.md
Name: id_ex_bubble_reg

Overview:
- ID/EX pipeline register for the 19-bit CPU; consumer of the load-use `hazard` flag that the hazard detection unit produces.
- Captures decoded ID-stage fields each cycle and drives the EX-stage fields (`EX_memread`, `EX_rt`, …) back into hazard detection and forwarding.
- On `hazard` or `flush` it loads a bubble (NOP) instead of the ID contents.
- A consecutive-stall watchdog flags pipeline deadlock.

Parameters:
- DATA_W, 19, datapath word width.
- REG_W, 3, register index width (8 registers).
- ALUOP_W, 4, ALU operation code width.
- MAX_STALL, 4, consecutive bubble cycles tolerated before `stall_err` asserts.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard  in  1  load-use stall request from hazard detection.
- flush  in  1  branch/jump flush of the ID instruction.
- ID_valid  in  1  ID stage holds a real instruction.
- ID_rs, ID_rt, ID_rd  in  REG_W each  source and destination indices.
- ID_rs_data, ID_rt_data  in  DATA_W each  register file read data.
- ID_imm  in  DATA_W  sign-extended immediate.
- ID_aluop  in  ALUOP_W  ALU operation.
- ID_memread, ID_memwrite, ID_regwrite, ID_alusrc  in  1 each  control bits.
- EX_valid  out  1  EX holds a real instruction.
- EX_rs, EX_rt, EX_rd  out  REG_W each.
- EX_rs_data, EX_rt_data, EX_imm  out  DATA_W each.
- EX_aluop  out  ALUOP_W.
- EX_memread, EX_memwrite, EX_regwrite, EX_alusrc  out  1 each.
- bubble  out  1  registered; the current EX content is an inserted bubble.
- stall_err  out  1  sticky watchdog error.

Behaviour:
- **Reset.** Asynchronous reset clears every output to 0, FSM to RUN, and the stall counter to 0.
- **Load rule.** Registered, latency 1. At each rising edge:
  - `flush` = 1 → bubble.
  - else `hazard` = 1 → bubble.
  - else `ID_valid` = 0 → bubble.
  - otherwise load all ID fields, `EX_valid` = 1, `bubble` = 0.
- **Bubble content.** `EX_valid`, `EX_memread`, `EX_memwrite`, `EX_regwrite` and `EX_alusrc` = 0. `EX_aluop` = 0 (NOP). `EX_rs`, `EX_rt` and `EX_rd` = 0, so a bubble never re-triggers hazard or forwarding on register 0. Data and immediate fields = 0.
- **Bubble flag.** `bubble` = 1 only for hazard- or flush-induced bubbles; it stays 0 for `ID_valid` = 0 idle cycles.
- **Hazard deassertion.** A bubble forces `EX_memread` = 0 in the next cycle, so hazard detection deasserts. A load-use pair therefore costs exactly one bubble.
- **Simultaneous `flush` and `hazard`.** `flush` wins; outcome is the same bubble. The cycle counts as a flush for the watchdog (counter cleared, not incremented).
- **FSM states.**
  - RUN → STALL on a hazard bubble.
  - STALL → STALL while `hazard` persists; the counter increments, saturating at MAX_STALL.
  - STALL → RUN on the first non-hazard cycle; counter cleared.
  - Any state → RUN on `flush`.
- **Watchdog.** When the counter reaches MAX_STALL and `hazard` is still high, `stall_err` sets to 1. It stays set until `rst`.
- **Reset mid-stall.** Counter, FSM, `stall_err` and outputs clear immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ID_EX_STALL_COUNT_EN.
- **Defined.**
  - Adds output `stall_cycles`, 16 bits: free-running count of hazard-induced bubble cycles.
  - Saturates at 16'hFFFF, reset to 0.
  - Flush bubbles are not counted.
- **Undefined.** The port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `cpu_pkg`:
  - DATA_W and REG_W constants.
  - ALU opcode constants, including ALU_NOP = 0.
  - Stall FSM state typedef {RUN, STALL}.
  - A packed `id_ex_ctrl_t` struct for the four control bits.
- One natural sub-module: `stall_watchdog`, holding the FSM, saturating counter and sticky `stall_err`. The top level holds the pipeline register and bubble mux.

Test Plan:
- **Normal load.** `ID_valid` = 1, `ID_rt` = 2, `ID_rs` = 3, `ID_memread` = 1, `hazard` = 0 → next edge `EX_rt` = 2, `EX_rs` = 3, `EX_memread` = 1, `EX_valid` = 1, `bubble` = 0.
- **Load-use.** `hazard` = 1 with `ID_rt` = 4, `ID_regwrite` = 1 → next edge all EX controls 0, `EX_rt` = 0, `bubble` = 1. Drop `hazard` → following edge loads the ID fields with `EX_rt` = 4, `bubble` = 0.
- **Flush priority.** `flush` = 1 and `hazard` = 1 together → bubble, FSM RUN, counter 0. `stall_cycles` (if enabled) unchanged.
- **Watchdog.** `hazard` held high for 5 edges with MAX_STALL = 4 → `stall_err` rises after the 5th edge. It stays 1 after `hazard` = 0 and clears only on `rst`.
- **Asynchronous reset.** Assert `rst` mid-cycle while `EX_memread` = 1 → all outputs 0 before the next clock edge. `EX_valid` stays 0 on the first edge after `rst` deasserts if `ID_valid` = 0.
- **Idle.** `ID_valid` = 0 with `hazard` = 0 → `EX_valid` = 0 and `bubble` = 0. With ID_EX_STALL_COUNT_EN defined, `stall_cycles` does not increment.
